// File: rtl/pll_drp_reconfig.sv
// pll_drp_reconfig
//
// DRP reconfiguration master for a PLLE2_ADV / MMCME2_ADV style PLL. A start
// request holds the PLL in reset, then walks a compile-time table of
// read-modify-write operations over the DRP port. After the last write it
// releases reset, waits for LOCKED and reports completion with a one-cycle
// SRDY pulse. A DRP access that never answers, or a PLL that never locks,
// aborts the sequence, sets the sticky ERR flag and still pulses SRDY.
//
// Parameters
//   ENTRIES      number of table entries (1..32)
//   TABLE        ENTRIES*39 bits; entry i = TABLE[i*39 +: 39] = {addr[6:0],
//                mask[15:0], data[15:0]}. A mask bit of 1 keeps the existing
//                register bit, a mask bit of 0 takes the table data bit.
//   DRDY_TIMEOUT cycles allowed from DEN to DRDY before abort
//   LOCK_TIMEOUT cycles allowed in the lock wait before abort
//
// Ports
//   DCLK     in   clock, shared with the PLL DRP clock
//   RST_N    in   asynchronous active-low reset
//   SEN      in   start request, only looked at while idle
//   SRDY     out  one-cycle pulse at the end of a sequence (success or abort)
//   BUSY     out  high whenever a sequence is in progress
//   ERR      out  sticky abort flag, cleared when the next SEN is accepted
//   PLL_RST  out  PLL reset
//   LOCKED   in   PLL lock, asynchronous to DCLK
//   DADDR    out  DRP address
//   DEN      out  DRP enable (single-cycle strobe)
//   DWE      out  DRP write enable
//   DI       out  DRP write data
//   DO       in   DRP read data
//   DRDY     in   DRP access complete
//
// All outputs come straight from flops. They are loaded from the next-state
// decode so that each output lines up with the state it belongs to.

module pll_drp_reconfig #(
  parameter int                    ENTRIES      = 2,
  parameter logic [ENTRIES*39-1:0] TABLE        = '0,
  parameter int                    DRDY_TIMEOUT = 64,
  parameter int                    LOCK_TIMEOUT = 4096
) (
  input  logic        DCLK,
  input  logic        RST_N,
  input  logic        SEN,
  output logic        SRDY,
  output logic        BUSY,
  output logic        ERR,
  output logic        PLL_RST,
  input  logic        LOCKED,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int TMAX  = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int CNT_W = $clog2(TMAX + 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ENTRIES - 1);
  // The counter is zero in the first cycle of a wait state, so the last
  // permitted cycle is TIMEOUT-1.
  localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ASSERT    = 4'd1;
  localparam logic [3:0] ST_READ      = 4'd2;
  localparam logic [3:0] ST_WAIT_R    = 4'd3;
  localparam logic [3:0] ST_WRITE     = 4'd4;
  localparam logic [3:0] ST_WAIT_W    = 4'd5;
  localparam logic [3:0] ST_RELEASE   = 4'd6;
  localparam logic [3:0] ST_WAIT_LOCK = 4'd7;
  localparam logic [3:0] ST_DONE      = 4'd8;
  localparam logic [3:0] ST_ABORT     = 4'd9;

  // ---------------------------------------------------------------------
  // Table decode: split the flat parameter into per-entry fields.
  // ---------------------------------------------------------------------
  logic [6:0]  tbl_addr [ENTRIES];
  logic [15:0] tbl_mask [ENTRIES];
  logic [15:0] tbl_data [ENTRIES];

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_table
      assign tbl_addr[gi] = TABLE[gi*39 + 32 +: 7];
      assign tbl_mask[gi] = TABLE[gi*39 + 16 +: 16];
      assign tbl_data[gi] = TABLE[gi*39      +: 16];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [3:0]       state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             lock_meta_reg, lock_s_reg;
  logic [15:0]      merge_data;

  // LOCKED synchronizer. The chain is held clear outside WAIT_LOCK so that a
  // LOCKED level left over from before the reconfiguration can never be taken
  // as the new lock: the PLL must be seen locked for two full cycles after
  // its reset has been released.
  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) begin
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
    end else if (state_reg == ST_WAIT_LOCK) begin
      lock_meta_reg <= LOCKED;
      lock_s_reg    <= lock_meta_reg;
    end else begin
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
    end
  end

  // Read-modify-write merge for the current entry.
  assign merge_data = (DO & tbl_mask[idx_reg]) | (tbl_data[idx_reg] & ~tbl_mask[idx_reg]);

  // ---------------------------------------------------------------------
  // Next-state decode
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (SEN) begin
          state_next = ST_ASSERT;
          idx_next   = '0;
        end
      end
      ST_ASSERT: begin
        state_next = ST_READ;
      end
      ST_READ: begin
        state_next = ST_WAIT_R;
        cnt_next   = '0;
      end
      ST_WAIT_R: begin
        cnt_next = cnt_reg + 1'b1;
        if (DRDY) begin
          state_next = ST_WRITE;
        end else if (cnt_reg == DRDY_LAST) begin
          state_next = ST_ABORT;
        end
      end
      ST_WRITE: begin
        state_next = ST_WAIT_W;
        cnt_next   = '0;
      end
      ST_WAIT_W: begin
        cnt_next = cnt_reg + 1'b1;
        if (DRDY) begin
          if (idx_reg == LAST_IDX) begin
            state_next = ST_RELEASE;
          end else begin
            state_next = ST_READ;
            idx_next   = idx_reg + 1'b1;
          end
        end else if (cnt_reg == DRDY_LAST) begin
          state_next = ST_ABORT;
        end
      end
      ST_RELEASE: begin
        state_next = ST_WAIT_LOCK;
        cnt_next   = '0;
      end
      ST_WAIT_LOCK: begin
        cnt_next = cnt_reg + 1'b1;
        if (lock_s_reg) begin
          state_next = ST_DONE;
        end else if (cnt_reg == LOCK_LAST) begin
          state_next = ST_ABORT;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      ST_ABORT: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      SRDY      <= 1'b0;
      BUSY      <= 1'b0;
      ERR       <= 1'b0;
      PLL_RST   <= 1'b0;
      DADDR     <= 7'd0;
      DEN       <= 1'b0;
      DWE       <= 1'b0;
      DI        <= 16'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;

      BUSY <= (state_next != ST_IDLE);
      SRDY <= (state_next == ST_DONE) || (state_next == ST_ABORT);

      // PLL held in reset for the whole table walk; ABORT and RELEASE drop it.
      PLL_RST <= (state_next == ST_ASSERT) || (state_next == ST_READ) ||
                 (state_next == ST_WAIT_R) || (state_next == ST_WRITE) ||
                 (state_next == ST_WAIT_W);

      // READ and WRITE are always followed by a wait state, so DEN can
      // never be high on two consecutive cycles.
      DEN <= (state_next == ST_READ) || (state_next == ST_WRITE);
      DWE <= (state_next == ST_WRITE);

      // DADDR only moves when a new access is issued.
      if ((state_next == ST_READ) || (state_next == ST_WRITE)) begin
        DADDR <= tbl_addr[idx_next];
      end

      // DO is only trusted on the read completion; DI then holds through
      // the write and afterwards until the next read completes.
      if ((state_reg == ST_WAIT_R) && DRDY) begin
        DI <= merge_data;
      end

      if ((state_reg == ST_IDLE) && SEN) begin
        ERR <= 1'b0;
      end else if (state_next == ST_ABORT) begin
        ERR <= 1'b1;
      end
    end
  end

endmodule
